// File: rtl/nios_system_sysid_checker.sv
// Avalon-MM read master that fetches the system-ID and timestamp words and compares
// them against build-time values, giving a go/no-go result after reset or on demand.
module nios_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1571410521,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter int          MAX_RETRIES        = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
    localparam logic [2:0]  RETRY_LOAD  = 3'(MAX_RETRIES);

    typedef enum logic [3:0] {
        IDLE,
        RD_ID_SETUP,
        RD_ID,
        RETRY_ID,
        RD_TS_SETUP,
        RD_TS,
        RETRY_TS,
        CHECK,
        FAIL
    } state_t;

    state_t      state, state_next;
    logic [15:0] wait_cnt, wait_next, wait_inc;
    logic [2:0]  retry_cnt, retry_next;
    logic        stall_limit;
    logic        busy_next, done_next, read_next, address_next;

    assign wait_inc    = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;
    assign stall_limit = (wait_inc >= TIMEOUT_LIM);

    // Acceptance is checked before the stall limit, so a transfer that completes
    // in the same cycle the counter would expire still counts as accepted.
    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        retry_next = retry_cnt;
        case (state)
            IDLE: begin
                if (start) state_next = RD_ID_SETUP;
            end
            RD_ID_SETUP: begin
                wait_next  = 16'd0;
                retry_next = RETRY_LOAD;
                state_next = RD_ID;
            end
            RD_ID: begin
                if (!avm_waitrequest) begin
                    state_next = RD_TS_SETUP;
                end else begin
                    wait_next = wait_inc;
                    if (stall_limit) state_next = RETRY_ID;
                end
            end
            RETRY_ID: begin
                wait_next = 16'd0;
                if (retry_cnt == 3'd0) begin
                    state_next = FAIL;
                end else begin
                    retry_next = retry_cnt - 3'd1;
                    state_next = RD_ID;
                end
            end
            RD_TS_SETUP: begin
                wait_next  = 16'd0;
                retry_next = RETRY_LOAD;
                state_next = RD_TS;
            end
            RD_TS: begin
                if (!avm_waitrequest) begin
                    state_next = CHECK;
                end else begin
                    wait_next = wait_inc;
                    if (stall_limit) state_next = RETRY_TS;
                end
            end
            RETRY_TS: begin
                wait_next = 16'd0;
                if (retry_cnt == 3'd0) begin
                    state_next = FAIL;
                end else begin
                    retry_next = retry_cnt - 3'd1;
                    state_next = RD_TS;
                end
            end
            CHECK:   state_next = IDLE;
            FAIL:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so that reset forces every
    // output low even though the machine resets into the setup state.
    always_comb begin
        busy_next    = (state_next != IDLE);
        done_next    = (state_next == CHECK) || (state_next == FAIL);
        read_next    = (state_next == RD_ID) || (state_next == RD_TS);
        address_next = (state_next == RD_TS);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= RD_ID_SETUP;
            wait_cnt    <= 16'd0;
            retry_cnt   <= 3'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
        end else begin
            state       <= state_next;
            wait_cnt    <= wait_next;
            retry_cnt   <= retry_next;
            busy        <= busy_next;
            done        <= done_next;
            avm_read    <= read_next;
            avm_address <= address_next;
        end
    end

    // Results from the previous check stay visible until the next setup clears them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            id_value <= 32'd0;
            ts_value <= 32'd0;
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            if (state == RD_ID && !avm_waitrequest) id_value <= avm_readdata;
            if (state == RD_TS && !avm_waitrequest) ts_value <= avm_readdata;
            case (state)
                RD_ID_SETUP: begin
                    id_ok   <= 1'b0;
                    ts_ok   <= 1'b0;
                    timeout <= 1'b0;
                end
                CHECK: begin
                    id_ok <= (id_value == EXPECTED_ID);
                    ts_ok <= (ts_value == EXPECTED_TIMESTAMP);
                end
                FAIL:    timeout <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// Directed bench for the system-ID checker: two instances, one with default
// parameters and one with a short timeout and a single retry.
module tb_nios_system_sysid_checker;

    localparam logic [31:0] TS_GOOD = 32'd1571410521;

    int compared   = 0;
    int mismatched = 0;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Instance 1: default parameters
    logic        reset, start;
    logic        avm_address, avm_read, avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        busy, done, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;
    logic [31:0] id_word, ts_word;
    int          stall_cfg, stall_left;

    nios_system_sysid_checker dut (
        .clock(clock), .reset(reset), .start(start),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
        .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok),
        .timeout(timeout), .id_value(id_value), .ts_value(ts_value)
    );

    assign avm_readdata    = avm_address ? ts_word : id_word;
    assign avm_waitrequest = avm_read && (stall_left != 0);

    always @(posedge clock) begin
        if (!avm_read || !avm_waitrequest) stall_left <= stall_cfg;
        else if (stall_left > 0)           stall_left <= stall_left - 1;
    end

    // Address/read must hold while the slave stalls
    logic prev_stall = 1'b0;
    logic prev_addr  = 1'b0;
    int   stab_err   = 0;
    always @(posedge clock) begin
        if (!reset && prev_stall && (!avm_read || avm_address != prev_addr)) stab_err++;
        prev_stall <= !reset && avm_read && avm_waitrequest;
        prev_addr  <= avm_address;
    end

    // Instance 2: TIMEOUT_CYCLES=4, MAX_RETRIES=1
    logic        reset2, start2, stuck2;
    logic        avm_address2, avm_read2, avm_waitrequest2;
    logic [31:0] avm_readdata2;
    logic        busy2, done2, id_ok2, ts_ok2, timeout2;
    logic [31:0] id_value2, ts_value2;
    int          stall_cfg2, stall_left2;

    nios_system_sysid_checker #(.TIMEOUT_CYCLES(4), .MAX_RETRIES(1)) dut2 (
        .clock(clock), .reset(reset2), .start(start2),
        .avm_address(avm_address2), .avm_read(avm_read2),
        .avm_readdata(avm_readdata2), .avm_waitrequest(avm_waitrequest2),
        .busy(busy2), .done(done2), .id_ok(id_ok2), .ts_ok(ts_ok2),
        .timeout(timeout2), .id_value(id_value2), .ts_value(ts_value2)
    );

    assign avm_readdata2    = avm_address2 ? TS_GOOD : 32'd0;
    assign avm_waitrequest2 = avm_read2 && (stuck2 || stall_left2 != 0);

    always @(posedge clock) begin
        if (!avm_read2 || !avm_waitrequest2) stall_left2 <= stall_cfg2;
        else if (stall_left2 > 0)            stall_left2 <= stall_left2 - 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitDone(input string tag);
        int n = 0;
        while (!done && n < 300) begin
            @(negedge clock);
            n++;
        end
        checkOutput({tag, "_done_seen"}, 32'(done), 32'd1);
        @(negedge clock);
    endtask

    // Pulse start for one cycle and count edges until done is seen
    task automatic applyStimulus(input string tag, input int exp_latency);
        int lat;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 300) begin
            @(negedge clock);
            lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_latency));
        @(negedge clock);
        checkOutput({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    task automatic startDut2(input string tag, input int exp_latency);
        int lat;
        @(negedge clock);
        start2 = 1'b1;
        @(negedge clock);
        start2 = 1'b0;
        lat = 1;
        while (!done2 && lat < 300) begin
            @(negedge clock);
            lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_latency));
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [11:0] rd_seq, done_seq;
        int          done_cnt, n;

        reset = 1'b1; start = 1'b0; stall_cfg = 0; stall_left = 0;
        id_word = 32'd0; ts_word = TS_GOOD;
        reset2 = 1'b1; start2 = 1'b0; stuck2 = 1'b1; stall_cfg2 = 0; stall_left2 = 0;

        // Reset state
        repeat (3) @(negedge clock);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_read", 32'(avm_read), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd0);
        checkOutput("rst_id_value", id_value, 32'd0);

        // 1: automatic check after reset, zero-wait slave
        reset = 1'b0;
        waitDone("t1");
        checkOutput("t1_id_ok", 32'(id_ok), 32'd1);
        checkOutput("t1_ts_ok", 32'(ts_ok), 32'd1);
        checkOutput("t1_timeout", 32'(timeout), 32'd0);
        checkOutput("t1_ts_value", ts_value, TS_GOOD);

        // 2: wrong ID word
        id_word = 32'h1;
        applyStimulus("t2", 5);
        checkOutput("t2_id_ok", 32'(id_ok), 32'd0);
        checkOutput("t2_ts_ok", 32'(ts_ok), 32'd1);
        checkOutput("t2_id_value", id_value, 32'h1);

        // 3: three stall cycles per read
        id_word = 32'd0;
        stall_cfg = 3;
        applyStimulus("t3", 11);
        checkOutput("t3_id_ok", 32'(id_ok), 32'd1);
        checkOutput("t3_ts_ok", 32'(ts_ok), 32'd1);
        checkOutput("t3_addr_stable", 32'(stab_err), 32'd0);

        // 5: start during RD_TS and during done are ignored
        stall_cfg = 0;
        @(negedge clock);
        start = 1'b1;
        done_cnt = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clock);
            start = 1'b0;
            if (k == 1) checkOutput("t5_busy_c1", 32'(busy), 32'd1);
            if (k == 4) begin
                checkOutput("t5_rd_ts_c4", {30'd0, avm_read, avm_address}, 32'd3);
                start = 1'b1;
            end
            if (done) begin
                done_cnt++;
                start = 1'b1;
            end
        end
        start = 1'b0;
        checkOutput("t5_done_count", 32'(done_cnt), 32'd1);
        checkOutput("t5_idle_read", 32'(avm_read), 32'd0);
        applyStimulus("t5_second", 5);
        checkOutput("t5_second_id_ok", 32'(id_ok), 32'd1);

        // 6: reset while reading the timestamp
        id_word = 32'h5A5A;
        stall_cfg = 3;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (!(avm_read && avm_address) && n < 50) begin
            @(negedge clock);
            n++;
        end
        checkOutput("t6_in_rd_ts", 32'(avm_read && avm_address), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("t6_read_drop", 32'(avm_read), 32'd0);
        checkOutput("t6_busy", 32'(busy), 32'd0);
        checkOutput("t6_id_value", id_value, 32'd0);
        checkOutput("t6_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd0);
        @(negedge clock);
        stall_cfg = 0;
        id_word = 32'd0;
        @(negedge clock);
        reset = 1'b0;
        waitDone("t6");
        checkOutput("t6_id_ok", 32'(id_ok), 32'd1);
        checkOutput("t6_ts_ok", 32'(ts_ok), 32'd1);

        // 4: stuck slave on the short-timeout instance
        @(negedge clock);
        reset2 = 1'b0;
        rd_seq = '0;
        done_seq = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            rd_seq[k-1]   = avm_read2;
            done_seq[k-1] = done2;
        end
        checkOutput("t4_read_pattern", 32'(rd_seq), 32'h1EF);
        checkOutput("t4_done_pattern", 32'(done_seq), 32'h400);
        checkOutput("t4_timeout", 32'(timeout2), 32'd1);
        checkOutput("t4_ok_flags", {30'd0, id_ok2, ts_ok2}, 32'd0);
        checkOutput("t4_idle", {30'd0, busy2, avm_read2}, 32'd0);

        // Acceptance on the last stall cycle before the limit still passes
        stuck2 = 1'b0;
        stall_cfg2 = 3;
        startDut2("bnd3", 11);
        checkOutput("bnd3_timeout", 32'(timeout2), 32'd0);
        checkOutput("bnd3_ok", {30'd0, id_ok2, ts_ok2}, 32'd3);

        // One stall cycle more hits the limit on every attempt
        stall_cfg2 = 4;
        startDut2("bnd4", 12);
        checkOutput("bnd4_timeout", 32'(timeout2), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
